// File: rtl/tm1638_serial_phy.sv
// Bit-serial CLK/DIO driver for the TM1638: one byte out per write request,
// 4 key-scan bytes in per read request. STB framing lives in the caller.
module tm1638_serial_phy #(
  parameter int unsigned CLOCK_FREQ_MHz = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_write_en,
  input  logic [7:0] i_raw_data,
  input  logic       i_read_en,
  output logic [7:0] o_btn_state,
  output logic       o_tm1638_clk,
  inout  wire        io_tm1638_data,
  output logic       o_probe,
  output logic       o_idle
);

  // 9 bits covers the 2H read-wait phase for H up to 255.
  localparam int unsigned CntW = 9;
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLOCK_FREQ_MHz - 1);
  localparam logic [CntW-1:0] WaitM1 = CntW'(2 * CLOCK_FREQ_MHz - 1);

  typedef enum logic [2:0] {
    StIdle, StWrLow, StWrHigh, StWrTail, StRdWait, StRdLow, StRdHigh, StRdTail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [31:0]     shift_q, shift_d;
  logic [7:0]      btn_q, btn_d;
  logic            phase_done;
  logic            drive_en;

  assign phase_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = phase_done ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    unique case (state_q)
      StIdle: begin
        // Write wins when both requests arrive together.
        if (i_write_en) begin
          data_d  = i_raw_data;
          bit_d   = '0;
          cnt_d   = HalfM1;
          state_d = StWrLow;
        end else if (i_read_en) begin
          bit_d   = '0;
          cnt_d   = WaitM1;
          state_d = StRdWait;
        end
      end
      StWrLow: begin
        if (phase_done) begin
          cnt_d   = HalfM1;
          state_d = StWrHigh;
        end
      end
      StWrHigh: begin
        if (phase_done) begin
          cnt_d = HalfM1;
          if (bit_q == 5'd7) begin
            state_d = StWrTail;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StWrLow;
          end
        end
      end
      StWrTail: begin
        if (phase_done) state_d = StIdle;
      end
      StRdWait, StRdLow: begin
        if (phase_done) begin
          cnt_d   = HalfM1;
          state_d = (state_q == StRdWait) ? StRdLow : StRdHigh;
        end
      end
      StRdHigh: begin
        if (cnt_q == HalfM1) shift_d = {io_tm1638_data, shift_q[31:1]};
        if (phase_done) begin
          cnt_d = HalfM1;
          if (bit_q == 5'd31) begin
            state_d = StRdTail;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StRdLow;
          end
        end
      end
      StRdTail: begin
        if (phase_done) begin
          for (int k = 0; k < 4; k++) begin
            btn_d[k]     = shift_q[8*k];
            btn_d[k + 4] = shift_q[8*k + 4];
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      shift_q <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      btn_q   <= btn_d;
    end
  end

  assign drive_en       = (state_q == StWrLow) || (state_q == StWrHigh) || (state_q == StWrTail);
  assign io_tm1638_data = drive_en ? data_q[bit_q[2:0]] : 1'bz;
  assign o_tm1638_clk   = !((state_q == StWrLow) || (state_q == StRdLow));
  assign o_probe        = (state_q == StRdWait) || (state_q == StRdLow) ||
                          (state_q == StRdHigh) || (state_q == StRdTail);
  assign o_idle         = (state_q == StIdle) && !i_write_en && !i_read_en;
  assign o_btn_state    = btn_q;

endmodule

// File: tb/tb_tm1638_serial_phy.sv
// Directed bench for tm1638_serial_phy at H=2: table of write/read transactions
// plus hand-written reset and mid-read reset sequences.
module tb_tm1638_serial_phy;

  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] raw = 8'h00;
  logic [7:0] btn;
  logic       tclk, probe, idle;
  logic       tb_oe = 1'b0;
  logic       tb_val = 1'b0;
  wire        dio;

  assign dio = tb_oe ? tb_val : 1'bz;
  pullup (dio);

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tm1638_serial_phy #(.CLOCK_FREQ_MHz(H)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_write_en    (we),
    .i_raw_data    (raw),
    .i_read_en     (re),
    .o_btn_state   (btn),
    .o_tm1638_clk  (tclk),
    .io_tm1638_data(dio),
    .o_probe       (probe),
    .o_idle        (idle)
  );

  typedef struct {
    bit          is_read;
    bit          also_read;
    logic [7:0]  wdata;
    logic [31:0] rbytes;
    logic [7:0]  exp_bits;
    logic [7:0]  exp_btn;
    int          inject_at;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Released line: pull-up reads 1, and a bench-driven 0 is not overridden.
  task automatic check_released(input string name);
    tb_oe = 1'b0;
    #1;
    check($sformatf("%s dio pullup", name), {31'd0, dio}, 32'd1);
    tb_oe  = 1'b1;
    tb_val = 1'b0;
    #1;
    check($sformatf("%s dio overridable", name), {31'd0, dio}, 32'd0);
    tb_oe = 1'b0;
    #1;
  endtask

  task automatic run(input vec_t v, input string tag);
    int n, rises, falls, last_rise, spacing_bad, probe_bad;
    logic prev;
    logic [7:0] got_bits;
    @(negedge clk);
    if (v.is_read) begin
      re     = 1'b1;
      tb_oe  = 1'b1;
      tb_val = 1'b1;
    end else begin
      we  = 1'b1;
      raw = v.wdata;
      re  = v.also_read;
    end
    #1;
    check($sformatf("%s idle drops", tag), {31'd0, idle}, 32'd0);
    n = 0; rises = 0; falls = 0; last_rise = 0; spacing_bad = 0; probe_bad = 0;
    prev = 1'b1;
    got_bits = 8'h00;
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    while (!idle && n <= 400) begin
      if (tclk && !prev) begin
        if (rises > 0 && (n - last_rise) != 2 * H) spacing_bad++;
        if (!v.is_read && rises < 8) got_bits[rises] = dio;
        rises++;
        last_rise = n;
      end
      if (!tclk && prev) begin
        if (v.is_read && falls < 32) tb_val = v.rbytes[falls];
        falls++;
      end
      if (probe !== v.is_read) probe_bad++;
      if (v.inject_at == n) begin
        we  = 1'b1;
        raw = 8'h55;
      end else begin
        we = 1'b0;
      end
      prev = tclk;
      @(negedge clk);
      n++;
    end
    we = 1'b0;
    check($sformatf("%s busy cycles", tag), n, v.is_read ? 67 * H : 17 * H);
    check($sformatf("%s clk rises", tag), rises, v.is_read ? 32 : 8);
    check($sformatf("%s clk spacing errors", tag), spacing_bad, 0);
    check($sformatf("%s probe errors", tag), probe_bad, 0);
    if (!v.is_read) check($sformatf("%s dio bits", tag), {24'd0, got_bits}, {24'd0, v.exp_bits});
    check($sformatf("%s btn", tag), {24'd0, btn}, {24'd0, v.exp_btn});
    check($sformatf("%s clk idle high", tag), {31'd0, tclk}, 32'd1);
    check_released(tag);
  endtask

  initial begin
    int n, rises;
    logic prev;

    vecs[0] = '{0, 0, 8'h8F, 32'h0000_0000, 8'h8F, 8'h00, -1};
    vecs[1] = '{1, 0, 8'h00, 32'h1100_1001, 8'h00, 8'hA9, -1};
    vecs[2] = '{0, 1, 8'h3C, 32'h0000_0000, 8'h3C, 8'hA9, -1};  // write wins over read
    vecs[3] = '{1, 0, 8'h00, 32'h0000_EEFF, 8'h00, 8'h11, 50};  // write ignored while busy
    vecs[4] = '{1, 0, 8'h00, 32'h0000_0000, 8'h00, 8'h00, -1};
    vecs[5] = '{0, 0, 8'hC3, 32'h0000_0000, 8'hC3, 8'h00, -1};
    vecs[6] = '{1, 0, 8'h00, 32'h0110_11EE, 8'h00, 8'h6A, -1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset clk", {31'd0, tclk}, 32'd1);
    check("reset btn", {24'd0, btn}, 32'd0);
    check("reset idle", {31'd0, idle}, 32'd1);
    check("reset probe", {31'd0, probe}, 32'd0);
    check_released("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset after 10 read bits: abort at once, no result update.
    @(negedge clk);
    re     = 1'b1;
    tb_oe  = 1'b1;
    tb_val = 1'b1;
    @(negedge clk);
    re    = 1'b0;
    n     = 0;
    rises = 0;
    prev  = 1'b1;
    while (rises < 10 && n < 200) begin
      if (tclk && !prev) rises++;
      prev = tclk;
      if (rises < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("midrd reached 10 bits", rises, 10);
    check("midrd probe before reset", {31'd0, probe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrd clk", {31'd0, tclk}, 32'd1);
    check("midrd idle", {31'd0, idle}, 32'd1);
    check("midrd probe", {31'd0, probe}, 32'd0);
    check("midrd btn", {24'd0, btn}, 32'd0);
    check_released("midrd");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrd stays idle", {31'd0, idle}, 32'd1);
    check("midrd btn held", {24'd0, btn}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
